register_bank_mem: RTL
======================

REGISTER_BANK_MEM -- requirements
Module: register_bank_mem

Interface
Parameters:
REQ-001 The block SHALL have parameter NrOfBits, default 32: data word width, a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter NrOfRegs, default 16: entry count, a power of two and at least 2.
REQ-003 The block SHALL have parameter PresetValue, default all-ones: value written to every entry by a bulk preset.
REQ-004 The block SHALL have derived localparams AddrBits = clog2(NrOfRegs) and NrOfBytes = NrOfBits/8.
Ports:
REQ-005 Clock  in  1  single clock; all state updates on its rising edge.
REQ-006 Reset  in  1  reset, synchronous, active-low.
REQ-007 ClockEnable  in  1  global enable.
REQ-008 Tick  in  1  tick qualifier.
REQ-009 cs  in  1  select, 1 = deselected.
REQ-010 WrEn  in  1  write request.
REQ-011 WrAddr  in  AddrBits  write entry.
REQ-012 D  in  NrOfBits  write data.
REQ-013 ByteEn  in  NrOfBytes  per-byte write mask.
REQ-014 RdEn  in  1  read request.
REQ-015 RdAddr  in  AddrBits  read entry.
REQ-016 pre  in  1  bulk preset request.
REQ-017 clr  in  1  bulk clear request.
REQ-018 Q  out  NrOfBits  registered read data.
REQ-019 QValid  out  1  read-data strobe.
REQ-020 Busy  out  1  bulk sweep in progress.

Function
REQ-021 A "step" SHALL be any rising Clock edge with Reset=1, ClockEnable=1 and Tick=1; no state other than reset changes on a non-step edge.
REQ-022 On a step with WrEn=1, cs=0 and Busy=0, each byte of entry WrAddr whose ByteEn bit is 1 SHALL take the corresponding byte of D, and other bytes SHALL hold.
REQ-023 On a step with RdEn=1, cs=0 and Busy=0, Q SHALL load entry RdAddr and QValid SHALL be 1 after that edge (one-step latency).
REQ-024 On any other step, QValid SHALL be 0 after the edge and Q SHALL hold; on non-step edges, Q and QValid SHALL hold.
REQ-025 Q SHALL never be high-Z; with cs=1, Q holds its last value.
REQ-026 The FSM SHALL have states IDLE, PRESET and CLEAR, with a sweep index of AddrBits bits.
REQ-027 In IDLE, a step with clr=1 SHALL enter CLEAR; otherwise a step with pre=1 SHALL enter PRESET; the index starts at 0 and cs is ignored for sweep requests.
REQ-028 In PRESET or CLEAR, each step SHALL write PresetValue or 0 respectively to entry[index] and increment the index.
REQ-029 The step that writes entry NrOfRegs-1 SHALL return the FSM to IDLE, so a sweep takes exactly NrOfRegs steps.
REQ-030 Busy SHALL equal 1 whenever the FSM is not in IDLE.
REQ-031 While Busy=1, pre, clr, WrEn and RdEn SHALL be ignored.
REQ-032 The index SHALL wrap naturally; no out-of-range address exists.
REQ-033 The step that accepts pre or clr SHALL also ignore a WrEn or RdEn on that step.

Reset
REQ-034 A rising Clock edge with Reset=0 SHALL act regardless of ClockEnable and Tick.
REQ-035 Such an edge SHALL clear all entries, set Q to 0, QValid to 0, FSM to IDLE, index to 0 and Busy to 0.
REQ-036 A reset during a sweep SHALL abort the sweep immediately.

Configuration
REQ-037 With macro REG_BANK_BYPASS_EN defined, a step performing both a write and a read to the same address SHALL return the post-write word: D bytes where ByteEn=1, old bytes elsewhere.
REQ-038 Without REG_BANK_BYPASS_EN, that same step SHALL return the pre-write word.

Structure
REQ-039 The shared package register_bank_pkg SHALL hold the FSM state encoding (IDLE=0, PRESET=1, CLEAR=2) and the clog2 helper.
REQ-040 The sweep FSM and index SHALL be one sub-module, register_bank_sweep, outputting Busy, sweep write-enable, sweep address and sweep-data select.

Verification
REQ-041 NrOfBits=32, NrOfRegs=16: write 0xDEADBEEF to addr 3 with ByteEn=1111, then read addr 3 -> Q=0xDEADBEEF with QValid=1 exactly one step later.
REQ-042 Entry 5 = 0x11223344; write 0xAABBCCDD with ByteEn=0101 -> reading addr 5 gives 0x11BB33DD.
REQ-043 Pulse pre -> Busy=1 for exactly 16 steps, and reads of all 16 entries return 0xFFFFFFFF; pre and clr together -> all entries 0.
REQ-044 Tick=0 on alternate cycles during writes, reads and a sweep -> state advances only on Tick=1 edges, and the sweep takes 32 clocks.
REQ-045 Same-step write 0x12345678 and read to addr 7 (old 0) -> Q=0x12345678 with the macro, Q=0 without.
REQ-046 Reset=0 at sweep step 8 -> next cycle Busy=0, Q=0, QValid=0, and all entries read 0.

Source files
------------

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_pkg
// Description : Shared definitions for the register bank: sweep FSM state
//               encoding and a constant-evaluable ceil(log2) helper.
// Revision    : 1.0 - initial release
// ============================================================================
package register_bank_pkg;

    // Sweep FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESET = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;

    // ceil(log2(value)); used at elaboration time to size address buses
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : register_bank_pkg
`default_nettype wire

// File: rtl/register_bank_sweep.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_sweep
// Description : Bulk preset/clear sequencer. On an accepted request it walks
//               an index across every entry, one entry per step, and returns
//               to idle on the step that writes the last entry.
// Ports       : clk_i         - clock
//               rst_ni        - synchronous active-low reset
//               step_i        - qualified step (enable and tick both high)
//               pre_i, clr_i  - bulk preset / bulk clear requests
//               busy_o        - sweep in progress
//               sweep_we_o    - sweep owns the write port this step
//               sweep_addr_o  - entry being swept
//               sweep_zero_o  - 1: write zero, 0: write preset value
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_sweep
    import register_bank_pkg::*;
#(
    parameter int ADDR_BITS  = 4,
    parameter int NR_OF_REGS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 step_i,
    input  logic                 pre_i,
    input  logic                 clr_i,
    output logic                 busy_o,
    output logic                 sweep_we_o,
    output logic [ADDR_BITS-1:0] sweep_addr_o,
    output logic                 sweep_zero_o
);

    localparam logic [ADDR_BITS-1:0] c_last_idx = ADDR_BITS'(NR_OF_REGS - 1);

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (step_i) begin
            case (state_q)
                ST_IDLE: begin
                    idx_d = '0;
                    // clear has priority when both requests arrive together
                    if (clr_i) begin
                        state_d = ST_CLEAR;
                    end else if (pre_i) begin
                        state_d = ST_PRESET;
                    end
                end
                ST_PRESET, ST_CLEAR: begin
                    idx_d = idx_q + ADDR_BITS'(1);
                    if (idx_q == c_last_idx) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign sweep_we_o   = (state_q != ST_IDLE);
    assign sweep_addr_o = idx_q;
    assign sweep_zero_o = (state_q == ST_CLEAR);

endmodule : register_bank_sweep
`default_nettype wire

// File: rtl/register_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_mem
// Description : Register bank with byte-masked writes, one-step registered
//               reads and bulk preset/clear sweeps. All state advances only
//               on steps (ClockEnable and Tick high); reset acts on any edge.
// Ports       : Clock, Reset (sync, active-low), ClockEnable, Tick
//               cs (1 = deselected), WrEn/WrAddr/D/ByteEn write port
//               RdEn/RdAddr read request, pre/clr bulk sweep requests
//               Q/QValid registered read data and strobe, Busy sweep flag
// Config      : REG_BANK_BYPASS_EN - when defined, a same-step write and
//               read of one entry returns the post-write word; otherwise
//               the pre-write word is returned.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_mem
    import register_bank_pkg::*;
#(
    parameter int                    NrOfBits    = 32,
    parameter int                    NrOfRegs    = 16,
    parameter logic [NrOfBits-1:0]   PresetValue = '1,
    localparam int                   AddrBits    = clog2(NrOfRegs),
    localparam int                   NrOfBytes   = NrOfBits / 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 cs,
    input  logic                 WrEn,
    input  logic [AddrBits-1:0]  WrAddr,
    input  logic [NrOfBits-1:0]  D,
    input  logic [NrOfBytes-1:0] ByteEn,
    input  logic                 RdEn,
    input  logic [AddrBits-1:0]  RdAddr,
    input  logic                 pre,
    input  logic                 clr,
    output logic [NrOfBits-1:0]  Q,
    output logic                 QValid,
    output logic                 Busy
);

    logic [NrOfBits-1:0] mem_q [NrOfRegs];
    logic [NrOfBits-1:0] q_q, q_d;
    logic                qvalid_q;

    logic                step;
    logic                busy;
    logic                sweep_we;
    logic [AddrBits-1:0] sweep_addr;
    logic                sweep_zero;
    logic                wr_ok;
    logic                rd_ok;
    logic [NrOfBits-1:0] wr_word;
    logic [NrOfBits-1:0] rd_word;

    assign step = ClockEnable & Tick;

    register_bank_sweep #(
        .ADDR_BITS  (AddrBits),
        .NR_OF_REGS (NrOfRegs)
    ) u_sweep (
        .clk_i        (Clock),
        .rst_ni       (Reset),
        .step_i       (step),
        .pre_i        (pre),
        .clr_i        (clr),
        .busy_o       (busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr),
        .sweep_zero_o (sweep_zero)
    );

    // A step that starts a sweep (pre/clr while idle, cs irrelevant) also
    // swallows any host access presented alongside it.
    assign wr_ok = step & WrEn & ~cs & ~busy & ~pre & ~clr;
    assign rd_ok = step & RdEn & ~cs & ~busy & ~pre & ~clr;

    // Byte-merged word that a host write would leave in the entry
    for (genvar b = 0; b < NrOfBytes; b++) begin : g_byte
        assign wr_word[b*8 +: 8] = ByteEn[b] ? D[b*8 +: 8] : mem_q[WrAddr][b*8 +: 8];
    end

`ifdef REG_BANK_BYPASS_EN
    assign rd_word = (wr_ok && (WrAddr == RdAddr)) ? wr_word : mem_q[RdAddr];
`else
    assign rd_word = mem_q[RdAddr];
`endif

    assign q_d = rd_ok ? rd_word : q_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NrOfRegs; i++) begin
                mem_q[i] <= '0;
            end
            q_q      <= '0;
            qvalid_q <= 1'b0;
        end else if (step) begin
            if (sweep_we) begin
                mem_q[sweep_addr] <= sweep_zero ? '0 : PresetValue;
            end else if (wr_ok) begin
                mem_q[WrAddr] <= wr_word;
            end
            q_q      <= q_d;
            qvalid_q <= rd_ok;
        end
    end

    assign Q      = q_q;
    assign QValid = qvalid_q;
    assign Busy   = busy;

endmodule : register_bank_mem
`default_nettype wire
